// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : Rx_async byte handshake, FWFT receive FIFO with per-byte error
//           flags, and threshold / timeout / overflow interrupt generation.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              baud_clock,
    input  logic              bit8,
    input  logic              parity_en,
    input  logic              receive_full,
    input  logic [7:0]        rx_data,
    input  logic              parity_err,
    input  logic              framing_err,
    output logic              read_rx_byte,
    output logic              clear_parity,
    output logic              clear_framing,
    input  logic              host_rd,
    output logic [7:0]        host_data,
    output logic              host_pe,
    output logic              host_fe,
    output logic [ADDR_W:0]   rx_level,
    output logic              rx_empty,
    output logic              rx_full,
    input  logic [ADDR_W:0]   threshold,
    input  logic              ovf_clear,
    output logic              overflow,
    output logic              timeout,
    input  logic [2:0]        irq_en,
    output logic              irq
);

    localparam int              c_depth_n    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_depth      = (ADDR_W+1)'(c_depth_n);
    localparam logic [11:0]     c_tmo_chars  = 12'(TIMEOUT_CHARS);
    localparam logic [11:0]     c_cnt_max    = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_read_rx_byte;
    logic              r_clear_parity;
    logic              r_clear_framing;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;
    logic [9:0]        r_mem [c_depth_n];
    logic              r_overflow;
    logic              r_timeout;
    logic [11:0]       r_cnt;

    logic              w_capture;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic              w_drop;
    logic              w_tmo_clr;
    logic              w_thr_hit;
    logic [3:0]        w_frame_bits;
    logic [7:0]        w_char_ticks;
    logic [11:0]       w_limit;
    logic [11:0]       w_cnt_next;
    logic [9:0]        w_head;

    assign rx_empty  = (r_level == '0);
    assign rx_full   = (r_level == c_depth);
    assign w_pop     = host_rd & ~rx_empty;
    assign w_capture = (r_state == ST_IDLE) & receive_full;
    // A full FIFO still has room when the host frees the head this same cycle.
    assign w_space   = ~rx_full | w_pop;
    assign w_push    = w_capture & w_space;
    assign w_drop    = w_capture & ~w_space;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_read_rx_byte  <= 1'b0;
            r_clear_parity  <= 1'b0;
            r_clear_framing <= 1'b0;
        end else begin
            r_read_rx_byte  <= 1'b0;
            r_clear_parity  <= 1'b0;
            r_clear_framing <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (receive_full) begin
                        r_read_rx_byte  <= 1'b1;
                        r_clear_parity  <= parity_err;
                        r_clear_framing <= framing_err;
                        r_state         <= ST_ACK;
                    end
                end
                ST_ACK:  r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (!receive_full) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign read_rx_byte  = r_read_rx_byte;
    assign clear_parity  = r_clear_parity;
    assign clear_framing = r_clear_framing;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {framing_err, parity_err, rx_data};
        end
    end

    assign w_head    = rx_empty ? 10'd0 : r_mem[r_rptr];
    assign host_data = w_head[7:0];
    assign host_pe   = w_head[8];
    assign host_fe   = w_head[9];
    assign rx_level  = r_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_frame_bits = 4'd9 + {3'b000, bit8} + {3'b000, parity_en};
    assign w_char_ticks = {w_frame_bits, 4'b0000};
    assign w_limit      = c_tmo_chars * {4'b0000, w_char_ticks};
    assign w_tmo_clr    = w_push | w_pop | rx_empty;
    assign w_cnt_next   = w_tmo_clr ? 12'd0 :
                          (baud_clock && (r_cnt != c_cnt_max)) ? r_cnt + 12'd1 : r_cnt;

    // Flag is set on the same edge the count reaches the limit, then held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_timeout <= w_tmo_clr ? 1'b0 : (r_timeout | (w_cnt_next >= w_limit));
        end
    end

    assign overflow  = r_overflow;
    assign timeout   = r_timeout;
    assign w_thr_hit = irq_en[0] & (threshold != '0) & (r_level >= threshold);
    assign irq       = w_thr_hit | (irq_en[1] & r_timeout) | (irq_en[2] & r_overflow);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Scoreboard bench for uart_rx_ctrl with a small Rx_async model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          baud_clock = 1'b0;
    logic          bit8 = 1'b1;
    logic          parity_en = 1'b0;
    logic          receive_full = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          parity_err = 1'b0;
    logic          framing_err = 1'b0;
    logic          read_rx_byte;
    logic          clear_parity;
    logic          clear_framing;
    logic          host_rd = 1'b0;
    logic [7:0]    host_data;
    logic          host_pe;
    logic          host_fe;
    logic [AW:0]   rx_level;
    logic          rx_empty;
    logic          rx_full;
    logic [AW:0]   threshold = '0;
    logic          ovf_clear = 1'b0;
    logic          overflow;
    logic          timeout;
    logic [2:0]    irq_en = 3'b000;
    logic          irq;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [9:0]    sb_q[$];
    int            exp_level = 0;
    logic          exp_ovf   = 1'b0;

    uart_rx_ctrl #(.ADDR_W(AW), .TIMEOUT_CHARS(4)) dut (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
        .parity_en(parity_en), .receive_full(receive_full), .rx_data(rx_data),
        .parity_err(parity_err), .framing_err(framing_err),
        .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
        .clear_framing(clear_framing), .host_rd(host_rd), .host_data(host_data),
        .host_pe(host_pe), .host_fe(host_fe), .rx_level(rx_level),
        .rx_empty(rx_empty), .rx_full(rx_full), .threshold(threshold),
        .ovf_clear(ovf_clear), .overflow(overflow), .timeout(timeout),
        .irq_en(irq_en), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Receiver model: present a byte, wait for the acknowledge, then drop it.
    task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe, input bit pop_same);
        int         n;
        bit         space;
        logic [9:0] exp;
        @(negedge clk);
        space = (exp_level < DEPTH) || (pop_same && exp_level > 0);
        if (pop_same && exp_level > 0) begin
            exp = sb_q.pop_front();
            n_checks++;
            if ({host_fe, host_pe, host_data} !== exp) begin
                n_fail++;
                $display("FAIL same_cycle_pop_head: got %h expected %h", {host_fe, host_pe, host_data}, exp);
            end
            host_rd = 1'b1;
            exp_level--;
        end
        rx_data = d; parity_err = pe; framing_err = fe; receive_full = 1'b1;
        if (space) begin
            sb_q.push_back({fe, pe, d});
            exp_level++;
        end else begin
            exp_ovf = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            host_rd = 1'b0;
            n++;
        end while (read_rx_byte !== 1'b1 && n < 8);
        n_checks++;
        if (n != 1) begin
            n_fail++;
            $display("FAIL ack_latency: got %0d cycles expected 1", n);
        end
        n_checks++;
        if ({clear_framing, clear_parity} !== {fe, pe}) begin
            n_fail++;
            $display("FAIL clear_pulses: got fe=%b pe=%b expected fe=%b pe=%b", clear_framing, clear_parity, fe, pe);
        end
        receive_full = 1'b0; parity_err = 1'b0; framing_err = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({read_rx_byte, clear_parity, clear_framing} !== 3'b000) begin
            n_fail++;
            $display("FAIL ack_one_cycle: got %b expected 000", {read_rx_byte, clear_parity, clear_framing});
        end
        n_checks++;
        if (rx_level !== (AW+1)'(exp_level)) begin
            n_fail++;
            $display("FAIL level_after_capture: got %0d expected %0d", rx_level, exp_level);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] exp;
        @(negedge clk);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h000;
        n_checks++;
        if ({host_fe, host_pe, host_data} !== exp) begin
            n_fail++;
            $display("FAIL %s: head got %h expected %h", tag, {host_fe, host_pe, host_data}, exp);
        end
        host_rd = 1'b1;
        @(negedge clk);
        host_rd = 1'b0;
        if (exp_level > 0) exp_level--;
        n_checks++;
        if (rx_level !== (AW+1)'(exp_level)) begin
            n_fail++;
            $display("FAIL %s_level: got %0d expected %0d", tag, rx_level, exp_level);
        end
    endtask

    task automatic baud(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); baud_clock = 1'b1;
            @(negedge clk); baud_clock = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rx_level, rx_empty, rx_full, overflow, timeout, irq} !== {3'd0, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_status: got lvl=%0d e=%b f=%b o=%b t=%b i=%b expected 0 1 0 0 0 0",
                     rx_level, rx_empty, rx_full, overflow, timeout, irq);
        end
        n_checks++;
        if ({read_rx_byte, clear_parity, clear_framing, host_fe, host_pe, host_data} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {read_rx_byte, clear_parity, clear_framing, host_fe, host_pe, host_data});
        end
    endtask

    task automatic test_basic();
        send_byte(8'h41, 1'b0, 1'b0, 1'b0);
        send_byte(8'h42, 1'b0, 1'b0, 1'b0);
        send_byte(8'h43, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (rx_level !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_level: got %0d expected 3", rx_level);
        end
        pop_check("basic_pop0");
        pop_check("basic_pop1");
        pop_check("basic_pop2");
        n_checks++;
        if ({rx_empty, host_data} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL basic_empty: got e=%b data=%h expected 1 00", rx_empty, host_data);
        end
        @(negedge clk); host_rd = 1'b1;
        @(negedge clk); host_rd = 1'b0;
        n_checks++;
        if ({rx_level, rx_empty} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_read_ignored: got lvl=%0d e=%b expected 0 1", rx_level, rx_empty);
        end
    endtask

    task automatic test_errors();
        send_byte(8'h55, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({host_pe, host_fe} !== 2'b11) begin
            n_fail++;
            $display("FAIL head_err_flags: got pe=%b fe=%b expected 1 1", host_pe, host_fe);
        end
        pop_check("err_pop");
    endtask

    task automatic test_threshold();
        irq_en = 3'b001; threshold = 3'd2;
        send_byte(8'h31, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_level1: got irq=%b expected 0", irq);
        end
        send_byte(8'h32, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_level2: got irq=%b expected 1", irq);
        end
        @(negedge clk); threshold = 3'd0;
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_disabled: got irq=%b expected 0", irq);
        end
        pop_check("thr_pop0");
        pop_check("thr_pop1");
        irq_en = 3'b000;
    endtask

    task automatic test_timeout();
        bit8 = 1'b1; parity_en = 1'b0;
        send_byte(8'h7E, 1'b0, 1'b0, 1'b0);
        baud(639);
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got %b expected 0 after 639 ticks", timeout);
        end
        baud(1);
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_at_limit: got %b expected 1 after 640 ticks", timeout);
        end
        irq_en = 3'b010;
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_irq: got %b expected 1", irq);
        end
        irq_en = 3'b000;
        pop_check("tmo_pop");
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pop_clear: got %b expected 0", timeout);
        end
        baud(700);
        @(negedge clk);
        n_checks++;
        if ({timeout, rx_empty} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_empty_hold: got t=%b e=%b expected 0 1", timeout, rx_empty);
        end
    endtask

    task automatic test_overflow();
        irq_en = 3'b100;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({rx_full, overflow} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_full: got f=%b o=%b expected 1 0", rx_full, overflow);
        end
        send_byte(8'h14, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({overflow, irq, rx_level} !== {exp_ovf, 1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL ovf_drop: got o=%b i=%b lvl=%0d expected %b 1 4", overflow, irq, rx_level, exp_ovf);
        end
        @(negedge clk); ovf_clear = 1'b1;
        @(negedge clk); ovf_clear = 1'b0;
        exp_ovf = 1'b0;
        n_checks++;
        if ({overflow, irq} !== {exp_ovf, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_clear: got o=%b i=%b expected 0 0", overflow, irq);
        end
        send_byte(8'h15, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({overflow, rx_full} !== {exp_ovf, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_push_pop_full: got o=%b f=%b expected 0 1", overflow, rx_full);
        end
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
        irq_en = 3'b000;
    endtask

    task automatic test_back_to_back_reset();
        int n;
        threshold = 3'd1; irq_en = 3'b001;
        send_byte(8'h21, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rx_data = 8'h22; receive_full = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (read_rx_byte !== 1'b1 && n < 8);
        @(negedge clk);
        n_checks++;
        if ({rx_level, irq} !== {3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset: got lvl=%0d irq=%b expected 2 1", rx_level, irq);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_level, rx_empty, rx_full, overflow, timeout, irq} !== {3'd0, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL midreset_status: got lvl=%0d e=%b f=%b o=%b t=%b i=%b expected 0 1 0 0 0 0",
                     rx_level, rx_empty, rx_full, overflow, timeout, irq);
        end
        n_checks++;
        if ({read_rx_byte, clear_parity, clear_framing, host_fe, host_pe, host_data} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {read_rx_byte, clear_parity, clear_framing, host_fe, host_pe, host_data});
        end
        receive_full = 1'b0;
        sb_q.delete();
        exp_level = 0;
        @(negedge clk); reset_n = 1'b1;
        threshold = 3'd0; irq_en = 3'b000;
        send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        pop_check("post_reset_pop");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_threshold();
        test_timeout();
        test_overflow();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the CoreUARTapb receiver. It runs the single-byte handshake with the `Rx_async` receiver: it takes each byte when `receive_full` rises, acknowledges it with `read_rx_byte`, and clears the receiver's sticky error flags. Accepted bytes and their per-byte error flags go into an internal first-word-fall-through FIFO. The block also generates level-threshold, receive-timeout and overflow interrupts for the APB register layer, which sits above it.

## Interface
- ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W entries; legal range 1..6
- TIMEOUT_CHARS, 4, idle character times before timeout asserts; legal range 1..15
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- baud_clock  in  1  x16 oversample enable, one clk wide
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  parity bit present in frame
- receive_full  in  1  receiver data-ready level
- rx_data  in  8  receiver data byte; valid while receive_full=1
- parity_err  in  1  receiver sticky parity error
- framing_err  in  1  receiver sticky framing error
- read_rx_byte  out  1  one-cycle acknowledge to receiver
- clear_parity  out  1  one-cycle clear of receiver parity error
- clear_framing  out  1  one-cycle clear of receiver framing error
- host_rd  in  1  pop strobe from register layer
- host_data  out  8  FIFO head byte (combinational from storage)
- host_pe  out  1  parity error of head entry
- host_fe  out  1  framing error of head entry
- rx_level  out  ADDR_W+1  number of occupied entries
- rx_empty  out  1  rx_level == 0
- rx_full  out  1  rx_level == DEPTH
- threshold  in  ADDR_W+1  interrupt level; 0 disables the threshold interrupt
- ovf_clear  in  1  clears overflow
- overflow  out  1  sticky: a byte was dropped
- timeout  out  1  receive timeout flag
- irq_en  in  3  {ovf, timeout, threshold} enables
- irq  out  1  OR of the enabled interrupt sources

## Operation
- Capture FSM states:
  - IDLE: when receive_full=1, latch {framing_err, parity_err, rx_data}.
    - If space is available, push the entry. Space is available when the FIFO is not full, or when it is full and host_rd pops in the same cycle.
    - Otherwise drop the byte and set overflow.
    - Go to ACK in both cases.
  - ACK: drive read_rx_byte=1 for one cycle.
    - Drive clear_parity=1 if the latched parity_err was 1.
    - Drive clear_framing=1 if the latched framing_err was 1.
    - Go to WAIT.
  - WAIT: stay until receive_full=0, then go to IDLE. This guarantees exactly one capture per byte.
- FIFO: write and read pointers are ADDR_W bits and wrap modulo DEPTH.
  - Push and pop in the same cycle leave rx_level unchanged.
  - host_rd while empty is ignored: no pointer move, no underflow.
  - After a pop, host_data/host_pe/host_fe show the next entry in the following cycle.
  - host_data, host_pe and host_fe read 0 while empty.
- Overflow: sticky, set on a dropped byte, cleared by ovf_clear. If set and clear happen in the same cycle, set wins.
- Timeout counter:
  - Character ticks = 16 × (1 start + 7+bit8 data + parity_en + 1 stop), i.e. 144..176.
  - Limit = TIMEOUT_CHARS × character ticks.
  - The counter is 12 bits, saturating, and advances only on baud_clock.
  - It clears to 0 on push, on pop, or while rx_empty=1.
  - timeout=1 when the counter reaches the limit. It stays 1 until the next push or pop, or until the FIFO empties.
- irq = (irq_en[0] & threshold≠0 & rx_level≥threshold) | (irq_en[1] & timeout) | (irq_en[2] & overflow).

## Timing
- Reset: FSM=IDLE, pointers=0, rx_level=0, rx_empty=1, rx_full=0, overflow=0, timeout=0, counter=0, irq=0, read_rx_byte/clear_*=0, host_* = 0.
- Reset asserted mid-operation: all entries are discarded immediately.
  - If receive_full is still 1 after reset releases, the pending byte is captured again.
- Latency (edge E = edge on which IDLE samples receive_full=1):
  - Push at E; rx_level updates after E.
  - read_rx_byte=1 in the cycle after E.
  - Receiver drops receive_full one cycle later.
  - Earliest next capture is 3 cycles after E.
- Pop at edge P: rx_level decrements after P.
- irq and status outputs are registered or derive from registered state. irq reflects a level change 0 cycles after rx_level changes.
- Changing bit8/parity_en mid-count takes effect on the next comparison; the counter is not reset.

## Test plan
- Three bytes (0x41, 0x42, 0x43) with errors clear:
  - read_rx_byte pulses exactly once per byte; clear_parity and clear_framing stay 0.
  - rx_level reaches 3; three pops return 0x41, 0x42, 0x43 in order.
  - rx_empty=1 afterwards.
- Byte 0x55 with parity_err=1 and framing_err=1:
  - host_pe=1 and host_fe=1 at the head.
  - clear_parity and clear_framing pulse together with read_rx_byte.
- ADDR_W=2: push 5 bytes with no pops:
  - rx_full=1 after the 4th; 5th byte is dropped and acknowledged; overflow=1.
  - irq=1 with irq_en=3'b100.
  - ovf_clear drops overflow to 0.
  - A further push with a same-cycle pop while full is accepted and overflow stays 0.
- bit8=1, parity_en=0, TIMEOUT_CHARS=4, one byte queued, no host reads:
  - timeout=1 after exactly 640 baud_clock ticks.
  - A pop clears it; the FIFO is then empty and timeout stays 0.
- threshold=2, irq_en=3'b001:
  - irq=0 at level 1 and 1 at level 2.
  - threshold=0 forces irq=0 at any level.
- reset_n pulsed low with 2 entries queued and the FSM in WAIT:
  - All outputs return to reset values.
  - Capture resumes correctly on the next receive_full.
